btn_event_ctrl: RTL

- Button-input controller for the memory-mapped peripheral side of the core.
- Debounces N_BTN raw buttons against one shared sampling tick and converts debounced transitions into press/release/auto-repeat events.
- Arbitrates all channels round-robin into a single valid/ready event port, consumed by the peripheral register interface.

---
 rtl/btn_evt_pkg.sv | 21 ++
 rtl/btn_channel.sv | 84 ++++++++
 rtl/btn_event_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller: event kinds, the per-channel
// pending slot, and the channel-id width helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_kind_e;

  typedef struct packed {
    logic      valid;
    evt_kind_e kind;
  } evt_slot_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, tick-driven debounce integrator,
// auto-repeat timer and a single-entry pending event slot.
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      tick_i,
  input  logic      btn_i,
  input  logic      repeat_en_i,
  input  logic      grant_i,
  output logic      level_o,
  output evt_slot_t slot_o,
  output logic      drop_o
);

  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);

  logic [1:0]    sync_q;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] rpt_cnt;
  logic          sync;
  logic          flip;
  logic          rpt_hit;
  logic          post;
  evt_kind_e     post_kind;

  assign sync = sync_q[1];

  always_comb begin
    flip      = tick_i && (sync != level_o) && (stab_cnt == SW'(STABLE_TICKS - 1));
    rpt_hit   = tick_i && !flip && level_o && repeat_en_i &&
                (rpt_cnt == RW'(REPEAT_DELAY - 1));
    post      = flip || rpt_hit;
    post_kind = EVT_REPEAT;
    if (flip) post_kind = level_o ? EVT_RELEASE : EVT_PRESS;
  end

  // A full slot that is not being granted this cycle cannot take the new event.
  assign drop_o = post && slot_o.valid && !grant_i && (post_kind != EVT_REPEAT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q   <= '0;
      stab_cnt <= '0;
      rpt_cnt  <= '0;
      level_o  <= 1'b0;
      slot_o   <= '{valid: 1'b0, kind: EVT_NONE};
    end else begin
      sync_q <= {sync_q[0], btn_i};

      if (tick_i) begin
        if (sync == level_o) begin
          stab_cnt <= '0;
        end else if (flip) begin
          level_o  <= ~level_o;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end

      if (flip || !level_o || !repeat_en_i) begin
        rpt_cnt <= '0;
      end else if (rpt_hit) begin
        rpt_cnt <= RW'(REPEAT_DELAY - REPEAT_RATE);
      end else if (tick_i) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end

      if (post && (!slot_o.valid || grant_i)) begin
        slot_o <= '{valid: 1'b1, kind: post_kind};
      end else if (grant_i) begin
        slot_o <= '{valid: 1'b0, kind: EVT_NONE};
      end
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller top: sampling tick, per-channel debounce/event
// generation, round-robin arbitration into one valid/ready event port.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 500000,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_BTN-1:0]           btn_i,
  input  logic [N_BTN-1:0]           repeat_en_i,
  output logic [N_BTN-1:0]           level_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(N_BTN)-1:0]   evt_id_o,
  output evt_kind_e                  evt_kind_o,
  output logic                       overflow_o,
  input  logic                       clr_ovf_i
);

  localparam int unsigned ID_W = id_w(N_BTN);
  localparam int unsigned TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  evt_slot_t       slot [N_BTN];
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] drop;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] gnt_id;
  evt_kind_e       gnt_kind;
  logic            found;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tick_i      (tick),
      .btn_i       (btn_i[g]),
      .repeat_en_i (repeat_en_i[g]),
      .grant_i     (grant[g]),
      .level_o     (level_o[g]),
      .slot_o      (slot[g]),
      .drop_o      (drop[g])
    );
  end

  // Search starts at ptr and wraps; only searches while the output register is free.
  always_comb begin
    found    = 1'b0;
    gnt_id   = '0;
    gnt_kind = EVT_NONE;
    scan_idx = '0;
    grant    = '0;
    if (!evt_valid_o) begin
      for (int unsigned k = 0; k < N_BTN; k++) begin
        scan_idx = ID_W'((32'(ptr) + k) % N_BTN);
        if (!found && slot[scan_idx].valid) begin
          found    = 1'b1;
          gnt_id   = scan_idx;
          gnt_kind = slot[scan_idx].kind;
        end
      end
    end
    if (found) grant[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_kind_o  <= EVT_NONE;
      ptr         <= '0;
    end else if (found) begin
      evt_valid_o <= 1'b1;
      evt_id_o    <= gnt_id;
      evt_kind_o  <= gnt_kind;
      ptr         <= (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
    end else if (evt_valid_o && evt_ready_i) begin
      evt_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          overflow_o <= 1'b0;
    else if (|drop)      overflow_o <= 1'b1;
    else if (clr_ovf_i)  overflow_o <= 1'b0;
  end

endmodule
